// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Shares the single cacheline-wide physical memory port between the
// instruction cache and the data cache. One request is latched at a time and
// presented on pmem until memory responds. The response is routed back to the
// cache that won. A mandatory RELEASE cycle follows every transaction.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_read, i_address          I-cache line-read request and address
//   i_rdata, i_resp            line data / completion back to the I-cache
//   d_read, d_write            D-cache line-read / writeback request
//   d_address, d_wdata         D-cache line address and writeback data
//   d_rdata, d_resp            line data / completion back to the D-cache
//   pmem_read, pmem_write      physical memory commands (never both high)
//   pmem_address, pmem_wdata   physical memory address and write data
//   pmem_rdata, pmem_resp      physical memory read data and completion
//   busy                       high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } state_t;

    state_t            state;
    state_t            next_state;

    // 0 = I-cache won last, 1 = D-cache won last
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              we_q;

    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;
    logic              in_grant;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Next-state and grant decode. Under contention the I-cache wins only
    // when the D-cache had the previous grant, giving strict alternation.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant)) begin
                    grant_i    = 1'b1;
                    next_state = GRANT_I;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    next_state = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register. An asserted reset drops straight back to IDLE, which
    // removes any in-flight command without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Transaction latch. The winner's address/data/command are captured at
    // the grant so later changes by the requester cannot disturb pmem.
    // A D-cache request with both read and write set is treated as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else if (grant_i) begin
            last_grant <= 1'b0;
            addr_q     <= i_address;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else if (grant_d) begin
            last_grant <= 1'b1;
            addr_q     <= d_address;
            wdata_q    <= d_wdata;
            we_q       <= d_write;
        end
    end

    // Commands are decoded purely from registered state, so they appear the
    // cycle after the grant and stay constant until the response.
    assign in_grant     = (state == GRANT_I) || (state == GRANT_D);
    assign pmem_read    = in_grant & ~we_q;
    assign pmem_write   = in_grant & we_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses are forwarded combinationally and only to the current
    // winner; a response arriving in IDLE or RELEASE goes nowhere.
    assign i_resp  = (state == GRANT_I) & pmem_resp;
    assign d_resp  = (state == GRANT_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    assign busy = (state != IDLE);

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single cacheline-wide physical memory port between the instruction cache and the data cache of the pipelined RISC-V core. It sits between the two caches and `pmem`.
- It latches one request at a time and drives it onto `pmem`.
- It routes the response back to the winning cache only.
- It grants alternately when both caches contend.

## Interface
- `ADDR_W`, default 32: physical address width.
- `LINE_W`, default 256: cacheline width in bits.
- `clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `i_read  in  1`: I-cache line-read request.
- `i_address  in  ADDR_W`: I-cache line address.
- `i_rdata  out  LINE_W`: line data returned to the I-cache.
- `i_resp  out  1`: I-cache transaction complete.
- `d_read  in  1`: D-cache line-read request.
- `d_write  in  1`: D-cache line-write (writeback) request.
- `d_address  in  ADDR_W`: D-cache line address.
- `d_wdata  in  LINE_W`: D-cache writeback data.
- `d_rdata  out  LINE_W`: line data returned to the D-cache.
- `d_resp  out  1`: D-cache transaction complete.
- `pmem_read  out  1`, `pmem_write  out  1`: physical memory commands.
- `pmem_address  out  ADDR_W`, `pmem_wdata  out  LINE_W`: physical memory address and write data.
- `pmem_rdata  in  LINE_W`, `pmem_resp  in  1`: physical memory read data and completion.
- `busy  out  1`: high in every state except IDLE.

## Operation
- **States.**
  - IDLE
  - GRANT_I
  - GRANT_D
  - RELEASE
- **Registers.**
  - `last_grant` (0 = I, 1 = D).
  - Latched `addr_q`, `wdata_q`, `we_q`.
- **IDLE.** Sample requests each cycle.
  - Only `i_read` asserted: go to GRANT_I.
  - Only `d_read|d_write` asserted: go to GRANT_D.
  - Both asserted: grant the requester not equal to `last_grant`.
  - On any grant: load `addr_q`, `wdata_q`, `we_q` from the winner and update `last_grant`.
- **GRANT_I / GRANT_D.**
  - Drive `pmem_address=addr_q`.
  - Drive `pmem_read=~we_q`, `pmem_write=we_q`, `pmem_wdata=wdata_q`.
  - Hold all of these constant until `pmem_resp`.
  - On `pmem_resp`, go to RELEASE.
- **Response routing.** Combinational, in the cycle `pmem_resp` is high.
  - Winner's `*_resp=1` and `*_rdata=pmem_rdata`.
  - Loser's `*_resp=0`.
  - Both `*_rdata` outputs show `pmem_rdata` at all times. It is valid only with the matching `*_resp`.
- **RELEASE.**
  - Lasts one cycle.
  - No pmem command is driven.
  - Requests are ignored.
  - Next state is IDLE. This gives each cache one cycle to deassert, so a stale request is never re-granted.
- **Latching.**
  - Requester inputs are latched at grant.
  - A requester changing its address or data after the grant does not affect the transaction in flight.
  - A requester must not withdraw its request before its resp. If it does, the transaction still completes and the resp is still pulsed.
- **Illegal D-cache request.** `d_read&d_write` together is illegal. The arbiter treats it as a write (`we_q=1`).
- **Stray response.** `pmem_resp` seen in IDLE or RELEASE is ignored: no `*_resp` output.
- **Mutual exclusion.** `pmem_read` and `pmem_write` are never high together.

## Timing
- **Reset.**
  - State=IDLE, `last_grant`=1, so the I-cache wins the first contention.
  - `addr_q`=0, `wdata_q`=0, `we_q`=0.
  - All `pmem_*` command outputs, `i_resp`, `d_resp` and `busy` are 0.
- **Reset mid-transaction.** Takes effect immediately.
  - Commands drop asynchronously.
  - The in-flight transaction is abandoned with no resp.
- **Grant latency.**
  - Request present in IDLE at edge N: command asserted after edge N, visible in cycle N+1.
  - Command outputs are registered.
- **Response latency.** `pmem_resp` in cycle M produces `*_resp` in the same cycle M.
- **Turnaround.**
  - State is RELEASE in M+1 and IDLE in M+2.
  - The next command can appear at cycle M+3 at the earliest.
  - Minimum transaction: 3 cycles plus the memory latency.
- **`busy`.** Decoded from state, so it is 1 in cycles N+1 through M+1.

## Test plan
- **I-cache read alone.**
  - Stimulus: `i_read`, `i_address=0x0000_0060`, memory returns pattern `A5…A5` after 5 cycles.
  - Required: `pmem_read` from N+1, `pmem_address=0x60`, `i_resp` one cycle high with `i_rdata=A5…A5`, `d_resp` stays 0.
- **D-cache writeback alone.**
  - Stimulus: `d_write`, `d_address=0x0000_1000`, `d_wdata=0x…DEADBEEF`.
  - Required: `pmem_write=1`, `pmem_read=0`, `pmem_wdata` matches, `d_resp` pulses once.
- **Contention.**
  - Stimulus: `i_read` and `d_read` asserted together, held, starting right after reset.
  - Required: I granted first. After RELEASE, D is granted. A second contention grants I again.
- **Address change after grant.**
  - Stimulus: D-cache changes `d_address` from 0x200 to 0x400 one cycle after grant.
  - Required: `pmem_address` stays 0x200 until resp.
- **Illegal request and stray response.**
  - Stimulus: `d_read&d_write` together.
  - Required: write performed. A `pmem_resp` injected while in IDLE produces no `*_resp`.
- **Async reset mid-transaction.**
  - Stimulus: deassert `rst_n` in GRANT_D.
  - Required: `pmem_write` and `busy` drop before the next edge. After release of reset, the next contention grants I.
